// File: rtl/rsa_pkg.sv
// Shared types and default widths for the RSA modular-exponentiation controller.
package rsa_pkg;

    localparam int N_W_DEF = 8;
    localparam int E_W_DEF = 9;
    localparam int M_W_DEF = 16;

    // Controller cycles per mod_mult operation: one issue cycle plus N_W iterations.
    localparam int MM_LAT = N_W_DEF + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SQR  = 3'd2,
        MUL  = 3'd3,
        DONE = 3'd4
    } modexp_state_t;

endpackage

// File: rtl/rsa_modexp_ctrl_mod_mult.sv
// Multi-cycle modular multiplier: p = (a*b) mod n, with a, b < n.
// Interleaved shift-add over the bits of b, MSB first, one bit per cycle.
// The cycle of 'start' latches the operands; the following N_W cycles iterate.
// 'done' and 'p' are valid together on the last iteration cycle.
module mod_mult
    import rsa_pkg::*;
#(
    parameter int N_W = N_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] a,
    input  logic [N_W-1:0] b,
    input  logic [N_W-1:0] n,
    output logic           done,
    output logic [N_W-1:0] p
);

    localparam int IW = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int AW = N_W + 2;

    logic [N_W-1:0] r_a;
    logic [N_W-1:0] r_b;
    logic [N_W-1:0] r_n;
    logic [N_W-1:0] r_acc2;
    logic [IW-1:0]  r_idx;
    logic           r_run;

    logic [AW-1:0]  w_n_ext;
    logic [AW-1:0]  w_sum;
    logic [AW-1:0]  w_sub1;
    logic [N_W-1:0] w_res;

    // One iteration: 2*acc + (b[i] ? a : 0) is below 3n, so two conditional
    // subtractions always bring it back below n.
    always_comb begin
        w_n_ext = {2'b00, r_n};
        w_sum   = {1'b0, r_acc2, 1'b0} + (r_b[r_idx] ? {2'b00, r_a} : '0);
        w_sub1  = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
        w_res   = N_W'((w_sub1 >= w_n_ext) ? (w_sub1 - w_n_ext) : w_sub1);
    end

    // Latch operands on start, then step one bit of b per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_n    <= '0;
            r_acc2 <= '0;
            r_idx  <= '0;
            r_run  <= 1'b0;
        end else if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_n    <= n;
            r_acc2 <= '0;
            r_idx  <= IW'(N_W - 1);
            r_run  <= 1'b1;
        end else if (r_run) begin
            r_acc2 <= w_res;
            r_idx  <= r_idx - IW'(1);
            if (r_idx == '0) begin
                r_run <= 1'b0;
            end
        end
    end

    assign done = r_run && (r_idx == '0);
    assign p    = w_res;

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Modular-exponentiation controller: c = m^e mod n, left-to-right
// square-and-multiply over one shared mod_mult, valid/ready on both sides.
// Optional build macro RSA_LZ_SKIP_EN: start the scan at the MSB set bit of e
// instead of scanning all E_W bits (the default gives a schedule that depends
// only on popcount(e)).
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// LOAD  | reduce m mod n, acc = 1 mod n, pick start bit; n == 0 flags error
// SQR   | acc = acc*acc mod n for bit k
// MUL   | acc = acc*mr mod n when e[k] is set
// DONE  | result held on res_c/res_err until res_ready
module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int E_W = E_W_DEF,
    parameter int M_W = M_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [M_W-1:0] req_msg,
    input  logic [E_W-1:0] req_e,
    input  logic [N_W-1:0] req_n,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N_W-1:0] res_c,
    output logic           res_err,
    output logic           busy
);

    localparam int KW = (E_W > 1) ? $clog2(E_W) : 1;

    modexp_state_t  r_state;
    modexp_state_t  w_next;

    logic [M_W-1:0] r_m;
    logic [E_W-1:0] r_e;
    logic [N_W-1:0] r_n;
    logic [N_W-1:0] r_acc;
    logic [N_W-1:0] r_mr;
    logic [KW-1:0]  r_k;
    logic           r_err;
    logic           r_pend;

    logic [M_W-1:0] w_div;
    logic [N_W-1:0] w_mr;
    logic [N_W-1:0] w_one_mod;
    logic [N_W-1:0] w_mm_b;
    logic           w_start;
    logic           w_mm_done;
    logic [N_W-1:0] w_mm_p;

`ifdef RSA_LZ_SKIP_EN
    function automatic logic [KW-1:0] msb_index(input logic [E_W-1:0] v);
        logic [KW-1:0] idx;
        idx = '0;
        for (int i = 0; i < E_W; i++) begin
            if (v[i]) begin
                idx = KW'(i);
            end
        end
        return idx;
    endfunction
`endif

    // Divisor forced to 1 when n == 0 so the remainder is always defined;
    // that case never uses mr.
    always_comb begin
        w_div     = (r_n == '0) ? M_W'(1) : M_W'(r_n);
        w_mr      = N_W'(r_m % w_div);
        w_one_mod = (r_n == N_W'(1)) ? '0 : N_W'(1);
        w_mm_b    = (r_state == MUL) ? r_mr : r_acc;
        w_start   = ((r_state == SQR) || (r_state == MUL)) && !r_pend;
    end

    mod_mult #(
        .N_W (N_W)
    ) u_mod_mult (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .a     (r_acc),
        .b     (w_mm_b),
        .n     (r_n),
        .done  (w_mm_done),
        .p     (w_mm_p)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                if (r_n == '0) begin
                    w_next = DONE;
`ifdef RSA_LZ_SKIP_EN
                end else if (r_e == '0) begin
                    w_next = DONE;
`endif
                end else begin
                    w_next = SQR;
                end
            end
            SQR: begin
                if (w_mm_done) begin
                    if (r_e[r_k]) begin
                        w_next = MUL;
                    end else if (r_k == '0) begin
                        w_next = DONE;
                    end
                end
            end
            MUL: begin
                if (w_mm_done) begin
                    w_next = (r_k == '0) ? DONE : SQR;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Request capture, operand setup and accumulator/bit-index updates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_m    <= '0;
            r_e    <= '0;
            r_n    <= '0;
            r_acc  <= '0;
            r_mr   <= '0;
            r_k    <= '0;
            r_err  <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pend <= 1'b0;
                    if (req_valid) begin
                        r_m   <= req_msg;
                        r_e   <= req_e;
                        r_n   <= req_n;
                        r_err <= 1'b0;
                    end
                end
                LOAD: begin
                    r_mr <= w_mr;
`ifdef RSA_LZ_SKIP_EN
                    r_k  <= msb_index(r_e);
`else
                    r_k  <= KW'(E_W - 1);
`endif
                    if (r_n == '0) begin
                        r_acc <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_acc <= w_one_mod;
                    end
                end
                SQR: begin
                    if (w_start) begin
                        r_pend <= 1'b1;
                    end
                    if (w_mm_done) begin
                        r_acc  <= w_mm_p;
                        r_pend <= 1'b0;
                        if (!r_e[r_k] && (r_k != '0)) begin
                            r_k <= r_k - KW'(1);
                        end
                    end
                end
                MUL: begin
                    if (w_start) begin
                        r_pend <= 1'b1;
                    end
                    if (w_mm_done) begin
                        r_acc  <= w_mm_p;
                        r_pend <= 1'b0;
                        if (r_k != '0) begin
                            r_k <= r_k - KW'(1);
                        end
                    end
                end
                default: begin
                    r_pend <= 1'b0;
                end
            endcase
        end
    end

    // Result fields are forced to zero outside DONE so nothing partial leaks out.
    assign req_ready = (r_state == IDLE) && rst;
    assign busy      = (r_state != IDLE);
    assign res_valid = (r_state == DONE);
    assign res_c     = res_valid ? r_acc : '0;
    assign res_err   = res_valid && r_err;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Scoreboard bench for rsa_modexp_ctrl: the driver queues expected results,
// a negedge monitor compares them when the result handshake happens.
module tb_rsa_modexp_ctrl;
    import rsa_pkg::*;

    localparam int N_W = N_W_DEF;
    localparam int E_W = E_W_DEF;
    localparam int M_W = M_W_DEF;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req_valid = 1'b0;
    logic           res_ready = 1'b1;
    logic [M_W-1:0] req_msg = '0;
    logic [E_W-1:0] req_e = '0;
    logic [N_W-1:0] req_n = '0;
    logic           req_ready;
    logic           res_valid;
    logic [N_W-1:0] res_c;
    logic           res_err;
    logic           busy;

    rsa_modexp_ctrl #(
        .N_W (N_W),
        .E_W (E_W),
        .M_W (M_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_msg   (req_msg),
        .req_e     (req_e),
        .req_n     (req_n),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_c     (res_c),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int err;
        int lat;
        int t0;
    } exp_t;

    exp_t q[$];
    exp_t mx;
    int   n_pass = 0;
    int   n_total = 0;
    bit   mon_seen = 1'b0;
    bit   idle_next = 1'b0;
    int   mon_lat = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    function automatic int popcnt(input int v);
        int c = 0;
        for (int i = 0; i < E_W; i++) if (v[i]) c++;
        return c;
    endfunction

    function automatic int bitlen(input int v);
        int b = 0;
        for (int i = 0; i < E_W; i++) if (v[i]) b = i + 1;
        return b;
    endfunction

    function automatic int exp_lat(input int e, input int n);
        if (n == 0) return 2;
`ifdef RSA_LZ_SKIP_EN
        if (e == 0) return 2;
        return 2 + (bitlen(e) + popcnt(e)) * MM_LAT;
`else
        return 2 + (E_W + popcnt(e)) * MM_LAT;
`endif
    endfunction

    // Plain repeated multiplication, independent of the bit-serial schedule.
    function automatic int ref_modexp(input int m, input int e, input int n);
        int r;
        int b;
        if (n == 0) return 0;
        r = 1 % n;
        b = m % n;
        for (int i = 0; i < e; i++) r = (r * b) % n;
        return r;
    endfunction

    task automatic send(input int m, input int e, input int n, input int c, input int err);
        exp_t x;
        @(negedge clk);
        req_msg   = M_W'(m);
        req_e     = E_W'(e);
        req_n     = N_W'(n);
        req_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (req_ready) begin
                x.c   = c;
                x.err = err;
                x.lat = exp_lat(e, n);
                x.t0  = cyc;
                q.push_back(x);
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", int'(req_ready), 1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && q.size() > 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);
    endtask

    task automatic hold_check();
        bit ok = 1'b1;
        int c0;
        int waited = 0;
        @(negedge clk);
        while (!res_valid && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        chk("hold_valid_seen", int'(res_valid), 1);
        c0 = int'(res_c);
        chk("hold_value", c0, 26);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!res_valid || int'(res_c) != c0 || req_ready || !busy) ok = 1'b0;
        end
        chk("hold_stable", int'(ok), 1);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
    endtask

    // Result monitor: latency measured at first res_valid, fields compared at handshake.
    always @(negedge clk) begin
        if (!rst) begin
            mon_seen  = 1'b0;
            idle_next = 1'b0;
        end else begin
            if (idle_next) begin
                chk("idle_after_hs", int'(req_ready), 1);
                idle_next = 1'b0;
            end
            if (res_valid) begin
                if (!mon_seen) begin
                    mon_seen = 1'b1;
                    if (q.size() == 0) chk("unexpected_result", int'(res_valid), 0);
                    else mon_lat = cyc - q[0].t0;
                end
                if (res_ready) begin
                    if (q.size() > 0) begin
                        mx = q.pop_front();
                        chk("res_c", int'(res_c), mx.c);
                        chk("res_err", int'(res_err), mx.err);
                        chk("latency", mon_lat, mx.lat);
                        idle_next = 1'b1;
                    end
                    mon_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #(10 * 95000);
        n_total++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        int cnt;
        int m;
        int e;
        int n;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_c", int'(res_c), 0);
        chk("rst_res_err", int'(res_err), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", int'(req_ready), 1);

        // Directed vectors, hand-computed results.
        send(5, 3, 33, 26, 0);
        send(2, 7, 33, 29, 0);
        send(29, 3, 33, 2, 0);
        send(7, 0, 33, 1, 0);
        send(5, 3, 1, 0, 0);
        send(66, 5, 33, 0, 0);
        send(300, 1, 33, 3, 0);
        send(123, 45, 0, 0, 1);
        drain();

        // Backpressure, with a second request held pending during it.
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        fork
            begin
                send(5, 3, 33, 26, 0);
                send(2, 7, 33, 29, 0);
            end
            hold_check();
        join
        drain();

        // Reset in the middle of the squaring phase.
        send(5, 3, 33, 26, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("busy_before_abort", int'(busy), 1);
        rst = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        chk("abort_req_ready", int'(req_ready), 0);
        chk("abort_res_valid", int'(res_valid), 0);
        chk("abort_res_c", int'(res_c), 0);
        chk("abort_res_err", int'(res_err), 0);
        chk("abort_busy", int'(busy), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_idle_ready", int'(req_ready), 1);
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (res_valid) cnt++;
        end
        chk("no_stale_valid", cnt, 0);
        send(2, 7, 33, 29, 0);
        drain();

        // Random sweep against the reference model.
        for (int i = 0; i < 150; i++) begin
            n = int'($urandom_range(255, 2));
            e = int'($urandom_range(511, 0));
            m = int'($urandom_range(65535, 0));
            send(m, e, n, ref_modexp(m, e, n), 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
